// File: rtl/int_sequencer_if.sv
// Control bundle between the pipeline (hazard/execute stages) and the interrupt sequencer.
interface int_sequencer_if;
  logic       int_req;
  logic       rti;
  logic       stall;
  logic       int_signal;
  logic       rti_signal;
  logic [1:0] counter_value;
  logic       fetch_freeze;
  logic       pc_load_vector;
  logic       pc_load_stack;
  logic       ccr_restore;
  logic       pending;

  // Pipeline side: raises requests, observes sequencer controls.
  modport master (
    output int_req, rti, stall,
    input  int_signal, rti_signal, counter_value, fetch_freeze,
           pc_load_vector, pc_load_stack, ccr_restore, pending
  );

  // Sequencer side.
  modport slave (
    input  int_req, rti, stall,
    output int_signal, rti_signal, counter_value, fetch_freeze,
           pc_load_vector, pc_load_stack, ccr_restore, pending
  );
endinterface

// File: rtl/int_sequencer.sv
// Interrupt entry/exit sequencer: drains the pipeline, pushes PC/CCR, vectors,
// and on RTI pops CCR/PC back. All outputs are registered decodes of the next state.
module int_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic          clk,
  input  logic          RESET,
  int_sequencer_if.slave bus
);

  localparam int unsigned DRAIN_W = 3;
  localparam int unsigned STEP_W  = 2;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    PUSH    = 3'd2,
    VECTOR  = 3'd3,
    POP     = 3'd4,
    RESTORE = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic                 pending_q, pending_d;
  logic                 int_q;
  logic                 int_edge;
  logic                 accept;

  logic                 int_signal_q, int_signal_d;
  logic                 rti_signal_q, rti_signal_d;
  logic [STEP_W-1:0]    counter_q, counter_d;
  logic                 freeze_q, freeze_d;
  logic                 load_vec_q, load_vec_d;
  logic                 load_stk_q, load_stk_d;
  logic                 ccr_rst_q, ccr_rst_d;

  // Next-state, request latch and output decode.
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    step_d   = step_q;

    if (!bus.stall) begin
      case (state_q)
        IDLE: begin
          if (bus.rti)        state_d = POP;
          else if (pending_q) state_d = DRAIN;
        end
        DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_d = PUSH;
            drain_d = '0;
          end else begin
            drain_d = drain_q + DRAIN_W'(1);
          end
        end
        PUSH: begin
          if (step_q == STEP_LAST) begin
            state_d = VECTOR;
            step_d  = '0;
          end else begin
            step_d  = step_q + STEP_W'(1);
          end
        end
        VECTOR:  state_d = IDLE;
        POP: begin
          if (step_q == STEP_LAST) begin
            state_d = RESTORE;
            step_d  = '0;
          end else begin
            step_d  = step_q + STEP_W'(1);
          end
        end
        RESTORE: state_d = IDLE;
        default: begin
          state_d = IDLE;
          drain_d = '0;
          step_d  = '0;
        end
      endcase
    end

    // A latched request is consumed only when IDLE actually moves to DRAIN; further edges are absorbed.
    int_edge  = bus.int_req & ~int_q;
    accept    = (state_q == IDLE) & ~bus.stall & ~bus.rti & pending_q;
    pending_d = pending_q ? ~accept : int_edge;

    int_signal_d = (state_d == PUSH);
    rti_signal_d = (state_d == POP);
    counter_d    = ((state_d == PUSH) || (state_d == POP)) ? step_d : '0;
    freeze_d     = (state_d != IDLE);
    load_vec_d   = (state_d == VECTOR);
    load_stk_d   = (state_d == RESTORE);
    ccr_rst_d    = (state_d == RESTORE);
  end

  // State, request sample and output registers.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q      <= IDLE;
      drain_q      <= '0;
      step_q       <= '0;
      pending_q    <= 1'b0;
      int_q        <= 1'b0;
      int_signal_q <= 1'b0;
      rti_signal_q <= 1'b0;
      counter_q    <= '0;
      freeze_q     <= 1'b0;
      load_vec_q   <= 1'b0;
      load_stk_q   <= 1'b0;
      ccr_rst_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      step_q       <= step_d;
      pending_q    <= pending_d;
      int_q        <= bus.int_req;
      int_signal_q <= int_signal_d;
      rti_signal_q <= rti_signal_d;
      counter_q    <= counter_d;
      freeze_q     <= freeze_d;
      load_vec_q   <= load_vec_d;
      load_stk_q   <= load_stk_d;
      ccr_rst_q    <= ccr_rst_d;
    end
  end

  assign bus.int_signal     = int_signal_q;
  assign bus.rti_signal     = rti_signal_q;
  assign bus.counter_value  = counter_q;
  assign bus.fetch_freeze   = freeze_q;
  assign bus.pc_load_vector = load_vec_q;
  assign bus.pc_load_stack  = load_stk_q;
  assign bus.ccr_restore    = ccr_rst_q;
  assign bus.pending        = pending_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: interrupt entry, RTI, stall, priority,
// re-request and asynchronous reset scenarios with hand-computed expectations.
module tb_int_sequencer;

  localparam int S_IDLE = 0, S_DRAIN = 1, S_PUSH = 2, S_VECTOR = 3, S_POP = 4, S_RESTORE = 5;

  logic clk;
  logic RESET;
  int   n_checks;
  int   n_errors;

  int_sequencer_if bus ();

  int_sequencer #(.DRAIN_CYCLES(3)) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // {int_signal, rti_signal, counter_value, fetch_freeze, pc_load_vector, pc_load_stack, ccr_restore, pending}
  function automatic logic [8:0] obs();
    return {bus.int_signal, bus.rti_signal, bus.counter_value, bus.fetch_freeze,
            bus.pc_load_vector, bus.pc_load_stack, bus.ccr_restore, bus.pending};
  endfunction

  function automatic logic [8:0] ev(input int st, input int cnt, input bit pend);
    logic [1:0] c;
    c = 2'(cnt);
    return {st == S_PUSH, st == S_POP, c, st != S_IDLE,
            st == S_VECTOR, st == S_RESTORE, st == S_RESTORE, pend};
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tc(input string tag, input int st, input int cnt, input bit pend);
    tick();
    check(tag, obs(), ev(st, cnt, pend));
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    RESET       = 1'b0;
    bus.int_req = 1'b0;
    bus.rti     = 1'b0;
    bus.stall   = 1'b0;

    #3;
    check("reset_state", obs(), 9'b0);
    @(negedge clk);
    RESET = 1'b1;

    // Basic interrupt; int_req then stays high to show a level does not re-arm
    bus.int_req = 1'b1;
    tc("basic_e1_pending", S_IDLE, 0, 1'b1);
    tc("basic_e2_drain", S_DRAIN, 0, 1'b0);
    tc("basic_e3_drain", S_DRAIN, 0, 1'b0);
    tc("basic_e4_drain", S_DRAIN, 0, 1'b0);
    tc("basic_e5_push0", S_PUSH, 0, 1'b0);
    tc("basic_e6_push1", S_PUSH, 1, 1'b0);
    tc("basic_e7_push2", S_PUSH, 2, 1'b0);
    tc("basic_e8_vector", S_VECTOR, 0, 1'b0);
    tc("basic_e9_idle", S_IDLE, 0, 1'b0);
    tc("level_no_rearm", S_IDLE, 0, 1'b0);
    bus.int_req = 1'b0;
    tc("basic_quiet", S_IDLE, 0, 1'b0);

    // RTI sequence; rti during POP is ignored; stall repeats the RESTORE pulse
    bus.rti = 1'b1;
    tc("rti_pop0", S_POP, 0, 1'b0);
    tc("rti_pop1_rti_ignored", S_POP, 1, 1'b0);
    bus.rti = 1'b0;
    tc("rti_pop2", S_POP, 2, 1'b0);
    tc("rti_restore", S_RESTORE, 0, 1'b0);
    bus.stall = 1'b1;
    tc("rti_restore_stalled", S_RESTORE, 0, 1'b0);
    bus.stall = 1'b0;
    tc("rti_idle", S_IDLE, 0, 1'b0);
    tc("rti_stays_idle", S_IDLE, 0, 1'b0);

    // Stall for two cycles while PUSH counter is 1
    bus.int_req = 1'b1;
    tc("stall_pending", S_IDLE, 0, 1'b1);
    bus.int_req = 1'b0;
    tc("stall_drain_a", S_DRAIN, 0, 1'b0);
    tc("stall_drain_b", S_DRAIN, 0, 1'b0);
    tc("stall_drain_c", S_DRAIN, 0, 1'b0);
    tc("stall_push0", S_PUSH, 0, 1'b0);
    tc("stall_push1", S_PUSH, 1, 1'b0);
    bus.stall = 1'b1;
    tc("stall_push1_hold1", S_PUSH, 1, 1'b0);
    tc("stall_push1_hold2", S_PUSH, 1, 1'b0);
    bus.stall = 1'b0;
    tc("stall_push2", S_PUSH, 2, 1'b0);
    tc("stall_vector", S_VECTOR, 0, 1'b0);
    tc("stall_idle", S_IDLE, 0, 1'b0);

    // rti and pending together in IDLE: POP first, then the interrupt
    bus.int_req = 1'b1;
    tc("prio_pending", S_IDLE, 0, 1'b1);
    bus.int_req = 1'b0;
    bus.rti     = 1'b1;
    tc("prio_pop0", S_POP, 0, 1'b1);
    bus.rti = 1'b0;
    tc("prio_pop1", S_POP, 1, 1'b1);
    tc("prio_pop2", S_POP, 2, 1'b1);
    tc("prio_restore", S_RESTORE, 0, 1'b1);
    tc("prio_idle", S_IDLE, 0, 1'b1);
    tc("prio_drain_a", S_DRAIN, 0, 1'b0);
    tc("prio_drain_b", S_DRAIN, 0, 1'b0);
    tc("prio_drain_c", S_DRAIN, 0, 1'b0);
    tc("prio_push0", S_PUSH, 0, 1'b0);
    tc("prio_push1", S_PUSH, 1, 1'b0);
    tc("prio_push2", S_PUSH, 2, 1'b0);
    tc("prio_vector", S_VECTOR, 0, 1'b0);
    tc("prio_idle_end", S_IDLE, 0, 1'b0);

    // Second edge during PUSH queues a second full service; rti in DRAIN is ignored
    bus.int_req = 1'b1;
    tc("two_pending", S_IDLE, 0, 1'b1);
    bus.int_req = 1'b0;
    tc("two_drain_a", S_DRAIN, 0, 1'b0);
    tc("two_drain_b", S_DRAIN, 0, 1'b0);
    tc("two_drain_c", S_DRAIN, 0, 1'b0);
    tc("two_push0", S_PUSH, 0, 1'b0);
    bus.int_req = 1'b1;
    tc("two_push1_edge", S_PUSH, 1, 1'b1);
    bus.int_req = 1'b0;
    tc("two_push2", S_PUSH, 2, 1'b1);
    tc("two_vector", S_VECTOR, 0, 1'b1);
    tc("two_idle_gap", S_IDLE, 0, 1'b1);
    tc("two_drain2_a", S_DRAIN, 0, 1'b0);
    bus.rti = 1'b1;
    tc("two_drain2_b_rti", S_DRAIN, 0, 1'b0);
    bus.rti = 1'b0;
    tc("two_drain2_c", S_DRAIN, 0, 1'b0);
    tc("two_push2_0", S_PUSH, 0, 1'b0);
    tc("two_push2_1", S_PUSH, 1, 1'b0);
    tc("two_push2_2", S_PUSH, 2, 1'b0);
    tc("two_vector2", S_VECTOR, 0, 1'b0);
    tc("two_idle_end", S_IDLE, 0, 1'b0);
    tc("two_no_rti_memory", S_IDLE, 0, 1'b0);

    // Asynchronous reset in DRAIN clears outputs before the next edge
    bus.int_req = 1'b1;
    tc("arst_pending", S_IDLE, 0, 1'b1);
    bus.int_req = 1'b0;
    tc("arst_drain", S_DRAIN, 0, 1'b0);
    #2;
    RESET = 1'b0;
    #1;
    check("arst_immediate", obs(), 9'b0);
    tick();
    check("arst_held", obs(), 9'b0);
    @(negedge clk);
    RESET = 1'b1;
    tc("arst_release_idle", S_IDLE, 0, 1'b0);
    tc("arst_stays_idle", S_IDLE, 0, 1'b0);

    // int_req already high when reset releases counts as an edge
    @(negedge clk);
    RESET       = 1'b0;
    bus.int_req = 1'b1;
    @(negedge clk);
    RESET = 1'b1;
    tc("rel_high_pending", S_IDLE, 0, 1'b1);
    bus.int_req = 1'b0;
    tc("rel_high_drain", S_DRAIN, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
